// File: rtl/tcam_lookup_pipe_if.sv
// Lookup request / result channel of the ternary match table.
//   key_valid/key_ready/key : lookup request (master -> slave)
//   res_valid/res_ready     : result handshake (slave -> master, ready from master)
//   res_hit/res_index/res_action : lookup result payload
// master = key producer / result consumer, slave = the table.
interface tcam_lookup_pipe_if #(
    parameter int KEY_W = 128,
    parameter int IDX_W = 4,
    parameter int ACT_W = 16
);
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key;
    logic             res_valid;
    logic             res_ready;
    logic             res_hit;
    logic [IDX_W-1:0] res_index;
    logic [ACT_W-1:0] res_action;

    modport master (
        output key_valid, key, res_ready,
        input  key_ready, res_valid, res_hit, res_index, res_action
    );

    modport slave (
        input  key_valid, key, res_ready,
        output key_ready, res_valid, res_hit, res_index, res_action
    );
endinterface

// File: rtl/tcam_lookup_pipe.sv
// Ternary match table with per-entry valid bits, action words, saturating
// hit counters, a 2-stage valid/ready lookup pipeline and a bulk-clear
// sequencer.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   bus (slave)        : key request in, lookup result out
//   i_wr_*             : atomic entry write (ignored while busy)
//   i_clr_start        : pulse, invalidate all entries and zero all counters
//   o_busy             : clear sequencer active
//   i_cnt_rd_addr      : hit counter read address
//   o_cnt_rd_data      : registered counter read, 1-cycle latency
module tcam_lookup_pipe #(
    parameter  int KEY_W   = 128,
    parameter  int ENTRIES = 16,
    parameter  int ACT_W   = 16,
    parameter  int CNT_W   = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    tcam_lookup_pipe_if.slave bus,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [KEY_W-1:0] i_wr_value,
    input  logic [KEY_W-1:0] i_wr_mask,
    input  logic [ACT_W-1:0] i_wr_action,
    input  logic             i_wr_entry_valid,
    input  logic             i_clr_start,
    output logic             o_busy,
    input  logic [IDX_W-1:0] i_cnt_rd_addr,
    output logic [CNT_W-1:0] o_cnt_rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic             r_busy;

    logic [KEY_W-1:0] r_value  [ENTRIES];
    logic [KEY_W-1:0] r_mask   [ENTRIES];
    logic [ACT_W-1:0] r_action [ENTRIES];
    logic [CNT_W-1:0] r_cnt    [ENTRIES];
    logic [ENTRIES-1:0] r_valid;

    logic             r_s1_valid;
    logic [KEY_W-1:0] r_s1_key;

    logic             r_res_valid;
    logic             r_res_hit;
    logic [IDX_W-1:0] r_res_index;
    logic [ACT_W-1:0] r_res_action;
    logic [CNT_W-1:0] r_cnt_rd;

    logic             w_adv;
    logic             w_key_ready;
    logic             w_accept;
    logic             w_cap;
    logic             w_wr;
    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    logic [ACT_W-1:0] w_act;

    assign w_adv       = !r_res_valid || bus.res_ready;
    assign w_key_ready = (r_state == S_IDLE) && (!r_s1_valid || w_adv);
    assign w_accept    = bus.key_valid && w_key_ready;
    assign w_cap       = r_s1_valid && w_adv;
    assign w_wr        = i_wr_en && (r_state == S_IDLE);

    // Priority match over the registered table; lowest index wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_act = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!w_hit && r_valid[i] &&
                ((r_s1_key & ~r_mask[i]) == (r_value[i] & ~r_mask[i]))) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
                w_act = r_action[i];
            end
        end
    end

    // Stage 1 and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_key     <= '0;
            r_res_valid  <= 1'b0;
            r_res_hit    <= 1'b0;
            r_res_index  <= '0;
            r_res_action <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_key   <= bus.key;
            end else if (w_cap) begin
                r_s1_valid <= 1'b0;
            end
            if (w_cap) begin
                r_res_valid  <= 1'b1;
                r_res_hit    <= w_hit;
                r_res_index  <= w_idx;
                r_res_action <= w_act;
            end else if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Entry payload has no reset; validity is carried by r_valid.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_value[i_wr_addr]  <= i_wr_value;
            r_mask[i_wr_addr]   <= i_wr_mask;
            r_action[i_wr_addr] <= i_wr_action;
        end
    end

    // Clear beats write beats increment for the same entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (r_state == S_CLEAR && r_ptr == IDX_W'(i)) begin
                    r_valid[i] <= 1'b0;
                    r_cnt[i]   <= '0;
                end else if (w_wr && i_wr_addr == IDX_W'(i)) begin
                    r_valid[i] <= i_wr_entry_valid;
                    r_cnt[i]   <= '0;
                end else if (w_cap && w_hit && w_idx == IDX_W'(i) && r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt_rd <= '0;
        else          r_cnt_rd <= r_cnt[i_cnt_rd_addr];
    end

    // Clear sequencer: wait for stage 1 to empty, then sweep one entry per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_clr_start) begin
                        r_state <= S_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!r_s1_valid) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_ptr == IDX_W'(ENTRIES - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_ready  = w_key_ready;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_hit    = r_res_hit;
    assign bus.res_index  = r_res_index;
    assign bus.res_action = r_res_action;
    assign o_busy         = r_busy;
    assign o_cnt_rd_data  = r_cnt_rd;

endmodule

// File: tb/tb_tcam_lookup_pipe.sv
// Scoreboard bench for tcam_lookup_pipe: expected results are queued when a
// key is accepted, and a monitor pops and compares each consumed result.
module tb_tcam_lookup_pipe;
    localparam int KEY_W = 128;
    localparam int ACT_W = 16;
    localparam int CNT_W = 2;
    localparam int IDX_W = 4;

    typedef struct {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [ACT_W-1:0] act;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [KEY_W-1:0] wr_value;
    logic [KEY_W-1:0] wr_mask;
    logic [ACT_W-1:0] wr_action;
    logic             wr_entry_valid;
    logic             clr_start;
    logic             busy;
    logic [IDX_W-1:0] cnt_rd_addr;
    logic [CNT_W-1:0] cnt_rd_data;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    tcam_lookup_pipe_if #(.KEY_W(KEY_W), .IDX_W(IDX_W), .ACT_W(ACT_W)) bus ();

    tcam_lookup_pipe #(.KEY_W(KEY_W), .ENTRIES(16), .ACT_W(ACT_W), .CNT_W(CNT_W)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .bus              (bus),
        .i_wr_en          (wr_en),
        .i_wr_addr        (wr_addr),
        .i_wr_value       (wr_value),
        .i_wr_mask        (wr_mask),
        .i_wr_action      (wr_action),
        .i_wr_entry_valid (wr_entry_valid),
        .i_clr_start      (clr_start),
        .o_busy           (busy),
        .i_cnt_rd_addr    (cnt_rd_addr),
        .o_cnt_rd_data    (cnt_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got idx %0d with empty scoreboard", bus.res_index);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_hit",    128'(bus.res_hit),    128'(e.hit));
                check("res_index",  128'(bus.res_index),  128'(e.idx));
                check("res_action", 128'(bus.res_action), 128'(e.act));
            end
        end
    end

    task automatic write_entry(input int addr, input logic [KEY_W-1:0] val,
                               input logic [KEY_W-1:0] msk, input logic [ACT_W-1:0] act,
                               input logic v);
        wr_en          = 1'b1;
        wr_addr        = IDX_W'(addr);
        wr_value       = val;
        wr_mask        = msk;
        wr_action      = act;
        wr_entry_valid = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Offers one key; queues the expectation on acceptance. Returns 1 time unit after the accepting edge.
    task automatic lookup(input logic [KEY_W-1:0] k, input logic h, input int idx, input logic [ACT_W-1:0] act);
        exp_t e;
        logic acc;
        int   waited;
        e.hit = h; e.idx = IDX_W'(idx); e.act = act;
        bus.key_valid = 1'b1;
        bus.key       = k;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = bus.key_ready;
            @(posedge clk); #1;
            waited++;
        end
        bus.key_valid = 1'b0;
        if (acc) sb.push_back(e);
        else     check("lookup_accept_timeout", 128'(acc), 128'(1));
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.res_valid && !busy) done = 1'b1;
        end
        if (!done) check("drain_timeout", 128'(done), 128'(1));
        @(posedge clk); #1;
    endtask

    task automatic rd_cnt(input int addr, input logic [CNT_W-1:0] exp, input string name);
        cnt_rd_addr = IDX_W'(addr);
        @(posedge clk); #1;
        check(name, 128'(cnt_rd_data), 128'(exp));
    endtask

    logic [KEY_W-1:0] KA, K5, KC, KD, KE, K0, ONES;

    initial begin
        KA   = {32{4'hA}};
        K5   = {32{4'h5}};
        KC   = {32{4'hC}};
        KD   = {32{4'hD}};
        KE   = {32{4'hE}};
        K0   = '0;
        ONES = '1;

        rst_n = 1'b0;
        bus.key_valid = 1'b0;
        bus.key       = '0;
        bus.res_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_value = '0; wr_mask = '0;
        wr_action = '0; wr_entry_valid = 1'b0;
        clr_start = 1'b0;
        cnt_rd_addr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid",  128'(bus.res_valid),  128'(0));
        check("rst_res_hit",    128'(bus.res_hit),    128'(0));
        check("rst_res_index",  128'(bus.res_index),  128'(0));
        check("rst_res_action", 128'(bus.res_action), 128'(0));
        check("rst_busy",       128'(busy),           128'(0));
        check("rst_cnt_rd",     128'(cnt_rd_data),    128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_key_ready", 128'(bus.key_ready), 128'(1));

        // Exact match on e3 with two-edge latency.
        write_entry(3, KA, '0, 16'h0033, 1'b1);
        lookup(KA, 1'b1, 3, 16'h0033);
        check("lat_not_yet", 128'(bus.res_valid), 128'(0));
        @(posedge clk); #1;
        check("lat_res_valid", 128'(bus.res_valid), 128'(1));
        wait_idle();
        rd_cnt(3, 2'd1, "cnt3_after_1hit");

        // Priority between e2 (exact) and e5 (all don't-care).
        write_entry(2, K5, '0, 16'h0022, 1'b1);
        write_entry(5, K0, ONES, 16'h0055, 1'b1);
        lookup(K5, 1'b1, 2, 16'h0022);
        wait_idle();
        write_entry(2, K5, '0, 16'h0022, 1'b0);
        lookup(K5, 1'b1, 5, 16'h0055);
        wait_idle();
        write_entry(5, K0, ONES, 16'h0055, 1'b0);
        lookup(K5, 1'b0, 0, 16'h0000);
        wait_idle();

        // Backpressure: three keys offered while results are stalled.
        write_entry(7, KC, '0, 16'h0077, 1'b1);
        begin
            logic [KEY_W-1:0] keys [3];
            exp_t             ex [3];
            int               j;
            logic             acc;
            keys[0] = KA; ex[0].hit = 1'b1; ex[0].idx = 4'd3; ex[0].act = 16'h0033;
            keys[1] = KC; ex[1].hit = 1'b1; ex[1].idx = 4'd7; ex[1].act = 16'h0077;
            keys[2] = K0; ex[2].hit = 1'b0; ex[2].idx = 4'd0; ex[2].act = 16'h0000;
            bus.res_ready = 1'b0;
            j = 0;
            for (int c = 0; c < 5; c++) begin
                bus.key_valid = 1'b1;
                bus.key = keys[j];
                @(negedge clk);
                acc = bus.key_ready;
                @(posedge clk); #1;
                if (acc) begin sb.push_back(ex[j]); j++; end
            end
            check("stall_accepted", 128'(j), 128'(2));
            check("stall_key_ready", 128'(bus.key_ready), 128'(0));
            bus.res_ready = 1'b1;
            for (int c = 0; c < 20 && j < 3; c++) begin
                bus.key = keys[j];
                @(negedge clk);
                acc = bus.key_ready;
                @(posedge clk); #1;
                if (acc) begin sb.push_back(ex[j]); j++; end
            end
            bus.key_valid = 1'b0;
            check("stall_all_accepted", 128'(j), 128'(3));
        end
        wait_idle();
        rd_cnt(3, 2'd2, "cnt3_after_2hits");

        // Write e4 on the same edge its lookup is compared.
        write_entry(4, KD, '0, 16'h0044, 1'b1);
        lookup(KD, 1'b1, 4, 16'h0044);
        write_entry(4, KD, '0, 16'h0099, 1'b1);
        rd_cnt(4, 2'd0, "cnt4_write_beats_inc");
        lookup(KD, 1'b1, 4, 16'h0099);
        wait_idle();

        // Saturating counter on e1.
        write_entry(1, KE, '0, 16'h0011, 1'b1);
        for (int n = 0; n < 5; n++) lookup(KE, 1'b1, 1, 16'h0011);
        wait_idle();
        rd_cnt(1, 2'd3, "cnt1_saturated");
        write_entry(1, KE, '0, 16'h0011, 1'b1);
        rd_cnt(1, 2'd0, "cnt1_rewritten");

        // Bulk clear started with a key held in stage 1.
        bus.res_ready = 1'b0;
        lookup(KA, 1'b1, 3, 16'h0033);
        lookup(KC, 1'b1, 7, 16'h0077);
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        begin
            int   n_busy;
            logic ended;
            n_busy = 0;
            ended  = 1'b0;
            for (int c = 0; c < 60 && !ended; c++) begin
                if (c == 0) check("busy_key_ready", 128'(bus.key_ready), 128'(0));
                if (c == 1) begin
                    wr_en = 1'b1; wr_addr = 4'd0; wr_value = KA; wr_mask = '0;
                    wr_action = 16'h00AA; wr_entry_valid = 1'b1;
                end
                if (c == 2) wr_en = 1'b0;
                if (c == 3) bus.res_ready = 1'b1;
                @(negedge clk);
                if (!busy) ended = 1'b1;
                else n_busy++;
                @(posedge clk); #1;
            end
            check("clear_ended", 128'(ended), 128'(1));
            check("busy_ge_17", 128'(n_busy >= 17), 128'(1));
            check("busy_le_24", 128'(n_busy <= 24), 128'(1));
        end
        wait_idle();
        lookup(KA, 1'b0, 0, 16'h0000);
        lookup(KC, 1'b0, 0, 16'h0000);
        lookup(KD, 1'b0, 0, 16'h0000);
        wait_idle();
        rd_cnt(3, 2'd0, "cnt3_cleared");
        rd_cnt(4, 2'd0, "cnt4_cleared");
        rd_cnt(7, 2'd0, "cnt7_cleared");

        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
